uart_tx_fifo: RTL

Transmit buffer between the Z80 bus decoder and the simpleuart transmitter. It captures bytes the CPU writes to 0xffff into a small FIFO and drains them into the UART one at a time, honouring the UART's wait handshake. It also exports the busy/ready status the decoder returns at 0xfffd. The CPU stalls only when the FIFO is full, not on every character.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit buffer between the Z80 bus decoder and the simpleuart transmitter.
// Each CPU write cycle to the data port pushes one byte into the FIFO. Bytes are
// drained into the UART one at a time, and the UART's wait handshake is obeyed.
// The CPU stalls only when the FIFO is full. It sees this condition through
// tx_busy.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   wr_req     in   write strobe, level-high for the whole CPU write cycle
//   wr_data    in   byte written by the CPU (sampled on the push cycle)
//   uart_we    out  write-enable to the UART (registered)
//   uart_data  out  byte presented to the UART (head of FIFO)
//   uart_wait  in   UART not accepting this cycle
//   full       out  FIFO holds 2^DEPTH_LOG2 entries
//   empty      out  FIFO holds no entries
//   level      out  current entry count
//   tx_busy    out  not-ready status for the CPU (equals full)
//   overflow   out  sticky: a push was dropped because the FIFO was full
//   ovf_clear  in   clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  uart_we,
  output logic [WIDTH-1:0]      uart_data,
  input  logic                  uart_wait,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  tx_busy,
  output logic                  overflow,
  input  logic                  ovf_clear
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_req_q;

  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic [DEPTH_LOG2:0]   level_next;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign tx_busy = full;

  // The head byte is shown only while uart_we is high. Memory contents are
  // undefined after reset, so the output is zero while the FIFO is empty.
  assign uart_data = uart_we ? mem[rd_ptr] : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    push       = wr_req & ~wr_req_q;
    pop        = uart_we & ~uart_wait;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;
    level_next = level;
    case ({accept, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // NOTE: the storage array has no reset. Resetting the pointers is enough to
  // discard its contents, and without a reset the array can map to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples values from before the edge.
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      uart_we  <= 1'b0;
      overflow <= 1'b0;
      // Start high so that a strobe still held when reset is released does
      // not count as a new push.
      wr_req_q <= 1'b1;
    end else begin
      wr_req_q <= wr_req;
      level    <= level_next;
      // uart_we shows the occupancy after this edge, so a byte appears on
      // the cycle after its push. There is no same-cycle fall-through.
      uart_we  <= (level_next != '0);
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
